// File: rtl/alien_fire_pkg.sv
// Shared types and constants for the alien fire scheduler.
// The BURST_WAIT state exists only when ALIEN_FIRE_BURST_EN is defined.
package alien_fire_pkg;

`ifdef ALIEN_FIRE_BURST_EN
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    COUNT      = 3'd2,
    FIRE       = 3'd3,
    BURST_WAIT = 3'd4
  } fire_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    COUNT = 3'd2,
    FIRE  = 3'd3
  } fire_state_t;
`endif

  // Playfield has 14 alien columns, 0..13.
  localparam logic [3:0]  NUM_COLS = 4'd14;

  // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Low levels only get the two slowest speeds.
  localparam logic [1:0]  SPEED_MASK_SLOW = 2'b01;
  localparam logic [1:0]  SPEED_MASK_FULL = 2'b11;

  // One Galois step: shift right, fold the dropped bit into the taps.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Fold a raw 4-bit nibble into the 0..13 column range.
  function automatic logic [3:0] wrap_col(input logic [3:0] raw);
    return (raw < NUM_COLS) ? raw : raw - NUM_COLS;
  endfunction

endpackage

// File: rtl/alien_fire_scheduler_lfsr16.sv
// Free-running 16-bit Galois LFSR. Steps every clk; a non-zero seed
// keeps it out of the all-zero lock-up state.
module lfsr16
  import alien_fire_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] state
);

  // Advance one step per clock, reload the seed on reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= SEED;
    else         state <= lfsr_next(state);
  end

endmodule

// File: rtl/alien_fire_scheduler.sv
// Alien fire scheduler: frame-based countdown that shrinks with level,
// random column/speed per shot, hold-off while all alien rocket slots are busy.
// Optional feature macro: ALIEN_FIRE_BURST_EN (second shot BURST_GAP frames
// after the first one when level >= 4).
//
// Handshake: shootPulse is a one-clk request with no back-pressure; randCol
// and randSpeed are valid in the same clk and hold until the next pulse.
// dbg_state exposes the FSM state for observation.
module alien_fire_scheduler
  import alien_fire_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          BASE_INTERVAL = 60,
  parameter int          MIN_INTERVAL  = 8,
  parameter int          LEVEL_STEP    = 6,
  parameter int          BURST_GAP     = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       isGameMode,
  input  logic [2:0] level,
  input  logic [2:0] isActiveAliens,
  output logic       shootPulse,
  output logic [3:0] randCol,
  output logic [2:0] randSpeed,
  output logic [2:0] dbg_state
);

  fire_state_t       state, state_d;
  logic [7:0]        cnt, cnt_d;
  logic              fire_now;
  logic [15:0]       lfsr;
  logic [5:0]        lfsr_unused;
  logic signed [8:0] scaled;
  logic [7:0]        interval;
  logic [7:0]        arm_load;
  logic [1:0]        speed_mask;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .state  (lfsr)
  );

  // Only the low ten LFSR bits feed jitter, column and speed.
  assign lfsr_unused = lfsr[15:10];
  assign dbg_state   = state;

`ifdef ALIEN_FIRE_BURST_EN
  logic burst_done, burst_done_d;

  // Remembers that the current shot is already the burst follow-up.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) burst_done <= 1'b0;
    else         burst_done <= burst_done_d;
  end
`else
  localparam int burst_gap_unused = BURST_GAP;
`endif

  // Level-scaled interval: 9-bit signed so deep levels go negative before the clamp.
  always_comb begin
    scaled     = 9'(BASE_INTERVAL) - 9'(LEVEL_STEP * int'(level));
    interval   = (scaled < $signed(9'(MIN_INTERVAL))) ? 8'(MIN_INTERVAL) : scaled[7:0];
    arm_load   = interval + {4'd0, lfsr[3:0]};
    speed_mask = (level < 3'd2) ? SPEED_MASK_SLOW : SPEED_MASK_FULL;
  end

  // Next-state logic; leaving game mode overrides everything, including a pending shot.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    fire_now = 1'b0;
`ifdef ALIEN_FIRE_BURST_EN
    burst_done_d = burst_done;
`endif
    case (state)
      IDLE: begin
        if (isGameMode) state_d = ARM;
      end
      ARM: begin
        cnt_d   = arm_load;
        state_d = COUNT;
      end
      COUNT: begin
        if (startOfFrame) begin
          if (cnt == 8'd1) state_d = FIRE;
          else             cnt_d   = cnt - 8'd1;
        end
      end
      FIRE: begin
        if (isActiveAliens != 3'b111) begin
          fire_now = 1'b1;
          state_d  = ARM;
`ifdef ALIEN_FIRE_BURST_EN
          if ((level >= 3'd4) && !burst_done) begin
            state_d      = BURST_WAIT;
            cnt_d        = 8'(BURST_GAP);
            burst_done_d = 1'b1;
          end else begin
            burst_done_d = 1'b0;
          end
`endif
        end
      end
`ifdef ALIEN_FIRE_BURST_EN
      BURST_WAIT: begin
        if (startOfFrame) begin
          if (cnt == 8'd1) state_d = FIRE;
          else             cnt_d   = cnt - 8'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (!isGameMode) begin
      state_d  = IDLE;
      cnt_d    = cnt;
      fire_now = 1'b0;
`ifdef ALIEN_FIRE_BURST_EN
      burst_done_d = 1'b0;
`endif
    end
  end

  // State, counter and registered outputs; column/speed latch only on a shot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      shootPulse <= 1'b0;
      randCol    <= 4'd0;
      randSpeed  <= 3'd0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      shootPulse <= fire_now;
      if (fire_now) begin
        randCol   <= wrap_col(lfsr[7:4]);
        randSpeed <= {1'b0, lfsr[9:8] & speed_mask};
      end
    end
  end

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Bench for alien_fire_scheduler: reference LFSR model, expected shots
// queued when the deciding frame pulse is driven, checked when shootPulse rises.
module tb_alien_fire_scheduler;

  localparam int        BASE      = 60;
  localparam int        MIN_IV    = 8;
  localparam int        STEP      = 6;
  localparam int        STEP2     = 9;
  localparam int        GAP       = 4;
  localparam int        FRAME_GAP = 3;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FIRE  = 3'd3;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       isGameMode;
  logic       mode2;
  logic [2:0] level;
  logic [2:0] isActiveAliens;
  logic       shootPulse, shoot2;
  logic [3:0] randCol, col2;
  logic [2:0] randSpeed, speed2;
  logic [2:0] dbg_state, dbg_state2;

  logic [22:0] exp_q[$];
  logic [22:0] exp2_q[$];
  logic [15:0] m_lfsr;
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [3:0]  last_col, last_col2;
  logic [2:0]  last_speed, last_speed2;

  alien_fire_scheduler #(
    .LFSR_SEED(SEED), .BASE_INTERVAL(BASE), .MIN_INTERVAL(MIN_IV),
    .LEVEL_STEP(STEP), .BURST_GAP(GAP)
  ) u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .isGameMode(isGameMode), .level(level), .isActiveAliens(isActiveAliens),
    .shootPulse(shootPulse), .randCol(randCol), .randSpeed(randSpeed),
    .dbg_state(dbg_state)
  );

  // Second instance with a steeper step so level 7 hits the clamp.
  alien_fire_scheduler #(
    .LFSR_SEED(SEED), .BASE_INTERVAL(BASE), .MIN_INTERVAL(MIN_IV),
    .LEVEL_STEP(STEP2), .BURST_GAP(GAP)
  ) u_dut_clamp (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .isGameMode(mode2), .level(level), .isActiveAliens(isActiveAliens),
    .shootPulse(shoot2), .randCol(col2), .randSpeed(speed2),
    .dbg_state(dbg_state2)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference LFSR written bit by bit: bits 15,13,12,10 take the feedback.
  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic [15:0] n;
    for (int i = 0; i < 15; i++) n[i] = s[i+1];
    n[15] = s[0];
    n[13] = s[14] ^ s[0];
    n[12] = s[13] ^ s[0];
    n[10] = s[11] ^ s[0];
    return n;
  endfunction

  function automatic logic [6:0] model_shot(input logic [15:0] s, input logic [2:0] lvl);
    logic [3:0] c;
    logic [2:0] sp;
    c  = s[7:4];
    if (c >= 4'd14) c = c - 4'd14;
    sp = (lvl < 3'd2) ? {2'b00, s[8]} : {1'b0, s[9:8]};
    return {c, sp};
  endfunction

  // Driver helpers: every tick lands 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      if (resetN) m_lfsr = model_next(m_lfsr);
      #1;
    end
  endtask

  task automatic send_frames(input int k);
    for (int i = 0; i < k; i++) begin
      tick(FRAME_GAP - 1);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic push_shot(input bit use2);
    logic [22:0] e;
    e = {16'(cyc + 1), model_shot(m_lfsr, level)};
    if (use2) exp2_q.push_back(e);
    else      exp_q.push_back(e);
  endtask

  // Called in an ARM cycle. how: 0 = shoot, 1 = stop in FIRE, 2 = drop mode in FIRE.
  task automatic count_round(input int step, input bit use2, input int how);
    int iv;
    int n;
    iv = BASE - step * int'(level);
    if (iv < MIN_IV) iv = MIN_IV;
    n = iv + int'(m_lfsr[3:0]);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    send_frames(n);
    if (how == 0) begin
      push_shot(use2);
      tick();
    end else if (how == 2) begin
      isGameMode = 1'b0;
      tick();
      check("abort_on_fire_state", dbg_state, ST_IDLE);
    end
  endtask

  task automatic go_idle();
    isGameMode = 1'b0;
    mode2      = 1'b0;
    tick(3);
    check("idle_state", dbg_state, ST_IDLE);
    check("missing_pulse", exp_q.size(), 0);
    check("missing_pulse_clamp", exp2_q.size(), 0);
    exp_q.delete();
    exp2_q.delete();
  endtask

  // Scoreboard: compare shots against the queue, check hold between shots.
  always @(negedge clk) begin
    logic [22:0] e;
    if (resetN) begin
      if (shootPulse) begin
        if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, 32'(e[22:7]));
          check("rand_col", randCol, e[6:3]);
          check("rand_speed", randSpeed, e[2:0]);
          check("col_range", randCol <= 4'd13, 1);
          last_col   = e[6:3];
          last_speed = e[2:0];
        end
      end else begin
        check("hold_col", randCol, last_col);
        check("hold_speed", randSpeed, last_speed);
      end
      if (shoot2) begin
        if (exp2_q.size() == 0) check("unexpected_pulse_clamp", 1, 0);
        else begin
          e = exp2_q.pop_front();
          check("clamp_pulse_cycle", cyc, 32'(e[22:7]));
          check("clamp_rand_col", col2, e[6:3]);
          check("clamp_rand_speed", speed2, e[2:0]);
          last_col2   = e[6:3];
          last_speed2 = e[2:0];
        end
      end else begin
        check("clamp_hold_col", col2, last_col2);
        check("clamp_hold_speed", speed2, last_speed2);
      end
    end
  end

  task automatic clear_model();
    m_lfsr      = SEED;
    last_col    = 4'd0;
    last_speed  = 3'd0;
    last_col2   = 4'd0;
    last_speed2 = 3'd0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    clear_model();
    resetN = 1'b0; startOfFrame = 1'b0; isGameMode = 1'b0; mode2 = 1'b0;
    level = 3'd0; isActiveAliens = 3'b000;

    // Reset values
    tick(3);
    check("reset_pulse", shootPulse, 0);
    check("reset_col", randCol, 0);
    check("reset_speed", randSpeed, 0);
    check("reset_state", dbg_state, ST_IDLE);
    resetN = 1'b1;
    clear_model();

    // Idle for 200 frames: no shots, outputs stay at zero
    for (int i = 0; i < 200; i++) begin
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
    end
    check("idle_col", randCol, 0);
    check("idle_speed", randSpeed, 0);
    check("idle_state_after_frames", dbg_state, ST_IDLE);

    // Level 0: two back-to-back intervals
    level = 3'd0; isGameMode = 1'b1;
    tick();
    count_round(STEP, 1'b0, 0);
    check("lvl0_speed_range", randSpeed <= 3'd1, 1);
    count_round(STEP, 1'b0, 0);
    go_idle();

    // Level 7: 60 - 42 = 18 frames plus jitter
    level = 3'd7; isGameMode = 1'b1;
    tick();
    count_round(STEP, 1'b0, 0);
    go_idle();

    // Clamp: step 9 at level 7 falls below the minimum interval
    level = 3'd7; mode2 = 1'b1;
    tick();
    count_round(STEP2, 1'b1, 0);
    go_idle();
    check("clamp_idle_state", dbg_state2, ST_IDLE);

    // Slot hold-off: all slots busy at expiry, then one frees up
    level = 3'd2; isActiveAliens = 3'b111; isGameMode = 1'b1;
    tick();
    count_round(STEP, 1'b0, 1);
    send_frames(3);
    check("holdoff_state", dbg_state, ST_FIRE);
    isActiveAliens = 3'b110;
    push_shot(1'b0);
    tick(6);
    go_idle();
    isActiveAliens = 3'b000;

    // Mode abort mid-countdown, then a full restart, then abort on the fire clk
    level = 3'd1; isGameMode = 1'b1;
    tick(2);
    send_frames(10);
    isGameMode = 1'b0;
    tick();
    check("abort_mid_state", dbg_state, ST_IDLE);
    tick(4);
    isGameMode = 1'b1;
    tick();
    count_round(STEP, 1'b0, 0);
    count_round(STEP, 1'b0, 2);
    tick(4);
    go_idle();

    // Reset mid-countdown: immediate clear, then a full interval
    level = 3'd0; isGameMode = 1'b1;
    tick(2);
    send_frames(7);
    resetN = 1'b0;
    #1;
    check("midreset_state", dbg_state, ST_IDLE);
    check("midreset_col", randCol, 0);
    check("midreset_speed", randSpeed, 0);
    check("midreset_pulse", shootPulse, 0);
    tick(2);
    resetN = 1'b1;
    clear_model();
    tick();
    count_round(STEP, 1'b0, 0);
    go_idle();

    // Level 4: burst pair when enabled, otherwise a plain interval
    level = 3'd4; isGameMode = 1'b1;
    tick();
    count_round(STEP, 1'b0, 0);
`ifdef ALIEN_FIRE_BURST_EN
    send_frames(GAP);
    push_shot(1'b0);
    tick();
`endif
    count_round(STEP, 1'b0, 0);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alien_fire_scheduler.md
# alien_fire_scheduler

- Decides when the alien formation fires and supplies the random column and speed for each alien shot.
- Sits directly upstream of the rockets controller and drives its `shootPulse`, `randCol` and `randSpeed` inputs.
- Uses a free-running 16-bit LFSR and a frame-based countdown whose length shrinks with game level.
- Holds off firing while all three alien rocket slots are busy.

## Interface
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be non-zero.
- `BASE_INTERVAL`, 60: countdown length at level 0, in frames. Constraint: `BASE_INTERVAL` + 15 ≤ 255.
- `MIN_INTERVAL`, 8: lower clamp on the level-scaled interval. Must be ≥ 1.
- `LEVEL_STEP`, 6: frames removed from the interval per level.
- `BURST_GAP`, 4: frames between the two shots of a burst. Used only with the macro.
- `clk` in 1: system clock.
- `resetN` in 1: reset, asynchronous, active-low.
- `startOfFrame` in 1: one-clk pulse per frame (30 Hz).
- `isGameMode` in 1: high while gameplay is running.
- `level` in 3: current difficulty level, 0..7.
- `isActiveAliens` in 3: busy flags of the alien rocket slots, fed back from the rockets controller.
- `shootPulse` out 1: one-clk fire request.
- `randCol` out 4: starting column for the alien search, 0..13.
- `randSpeed` out 3: speed index, 0..3.

## Operation
- **LFSR**
  - Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk in all states, including IDLE, so player timing adds entropy.
  - Never reaches zero.
- **States:** IDLE, ARM, COUNT, FIRE, plus BURST_WAIT when the macro is defined.
  - Any state goes to IDLE on the next clk when `isGameMode` = 0.
  - IDLE → ARM when `isGameMode` = 1.
  - ARM (1 clk): load `cnt` = clamp(`BASE_INTERVAL` − `LEVEL_STEP`·`level`, `MIN_INTERVAL`) + `lfsr[3:0]`, then → COUNT. Compute the subtraction 9-bit signed; `cnt` is 8 bits.
  - COUNT: on each `startOfFrame`, if `cnt` = 1 → FIRE, else `cnt` is decremented. A shot therefore follows exactly N frame pulses after ARM, where N is the loaded value. A `startOfFrame` that arrives during the ARM cycle is not counted.
  - FIRE: wait while `isActiveAliens` = 3'b111. When any slot is free, register `shootPulse` = 1 for the next clk and latch the outputs:
    - `randCol` = `lfsr[7:4]` when < 14, otherwise `lfsr[7:4]` − 14.
    - `randSpeed` = {1'b0, `lfsr[9:8]` & mask}, where mask = 2'b01 for `level` < 2 and 2'b11 otherwise.
  - After FIRE the state goes to ARM (or to BURST_WAIT, see Configuration).
- A `level` change takes effect at the next ARM. A countdown already in progress is unaffected.
- `randCol` and `randSpeed` hold their values between pulses.

## Timing
- **Reset values:** state IDLE, `lfsr` = `LFSR_SEED`, `cnt` = 0, `shootPulse` = 0, `randCol` = 0, `randSpeed` = 0.
- All outputs are registered.
- `randCol` and `randSpeed` change in the same clk that `shootPulse` rises.
- `shootPulse` is high for exactly 1 clk and never twice in consecutive clks.
- Latency from a free slot in FIRE to `shootPulse` is 1 clk.
- If `isGameMode` falls in the same clk a pulse would be registered, the pulse is suppressed and the state goes to IDLE.
- Reset asserted mid-countdown returns every register to its reset value immediately. No pulse is emitted after reset releases until a full interval elapses.
- `startOfFrame` during FIRE is ignored.

## Configuration
- **`ALIEN_FIRE_BURST_EN` defined:**
  - When `level` ≥ 4, FIRE goes to BURST_WAIT instead of ARM.
  - BURST_WAIT counts `BURST_GAP` `startOfFrame` pulses, then re-enters FIRE for one more shot (with fresh column and speed). That FIRE then goes to ARM.
  - A 1-bit flag prevents chained bursts.
- **Not defined:** no BURST_WAIT state and no flag logic; FIRE always goes to ARM.

## Structure
- **Package `alien_fire_pkg`:**
  - State enum `fire_state_t`.
  - `NUM_COLS` = 14.
  - LFSR tap mask 16'hB400.
  - Speed masks.
- **Sub-module `lfsr16`:**
  - Inputs: `clk`, `resetN`, seed parameter.
  - Output: 16-bit `state`.
  - Advances every clk.

## Test plan
- **Reset and idle:** hold `isGameMode` = 0 for 200 frames → `shootPulse` never asserted, outputs remain 0, LFSR still advances (checked against a reference model).
- **Level-0 interval:** `level` = 0, slots free, model jitter j → first `shootPulse` exactly 60 + j frame pulses after ARM, `randSpeed` ≤ 1, `randCol` ≤ 13.
- **Clamp:** `level` = 7 → interval 60 − 42 = 18 frames (above the clamp). Then set `LEVEL_STEP` = 9 with `level` = 7 → interval `MIN_INTERVAL` = 8 + j.
- **Slot hold-off:** `isActiveAliens` = 3'b111 when the countdown expires → no pulse; drop it to 3'b110 → `shootPulse` on the next clk, once only.
- **Mode abort:** drop `isGameMode` in mid-countdown and on the pulse clk → no pulse, state IDLE. Raise it again → the countdown restarts from a full interval.
- **Burst (macro defined):** `level` = 4 → two pulses separated by exactly 4 frame pulses, then one normal interval. With the macro undefined → a single pulse.
